// File: rtl/lambdar_barrier_serializer_pkg.sv
// lambdar_pkg: constants and types shared by the barrier serializer slice.
//   LAMBDAR_NUM_LANES : default number of lanes per parallel block (12)
//   LAMBDAR_IDX_W     : width of the lane index presented on out_index (4)
//   state_e           : serializer state encoding (IDLE / DRAIN)
// No ports; imported by the interface, the top and the bench.
package lambdar_pkg;

    localparam int LAMBDAR_NUM_LANES = 12;
    localparam int LAMBDAR_IDX_W     = 4;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } state_e;

endpackage

// File: rtl/lambdar_barrier_serializer_if.sv
// lambdar_barrier_serializer_if: bundles the load side and the word stream
// of the barrier serializer.
//   load, in_flat, out_ready                    : driven by the master (producer/consumer side)
//   out_data, out_valid, out_index, out_last, busy : driven by the slave (serializer)
// Parameters DATAWIDTH / NUM_LANES must match the serializer instance.
interface lambdar_barrier_serializer_if
    import lambdar_pkg::*;
#(
    parameter int DATAWIDTH = 8,
    parameter int NUM_LANES = LAMBDAR_NUM_LANES
);

    logic                           load;
    logic [NUM_LANES*DATAWIDTH-1:0] in_flat;
    logic                           out_ready;
    logic [DATAWIDTH-1:0]           out_data;
    logic                           out_valid;
    logic [LAMBDAR_IDX_W-1:0]       out_index;
    logic                           out_last;
    logic                           busy;

    modport master (
        output load, in_flat, out_ready,
        input  out_data, out_valid, out_index, out_last, busy
    );

    modport slave (
        input  load, in_flat, out_ready,
        output out_data, out_valid, out_index, out_last, busy
    );

endinterface

// File: rtl/lambdar_barrier_serializer_reg.sv
// lambdar_barrier_serializer_reg: one lane word of the capture bank.
//   clock : rising-edge clock
//   reset : synchronous active-high clear
//   en    : load d into the register
//   d / q : lane word in / held lane word out
module lambdar_barrier_serializer_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_r;

    // Lane word storage: cleared by reset, captured on enable, else held
    always_ff @(posedge clock) begin
        if (reset) begin
            q_r <= {WIDTH{1'b0}};
        end else if (en) begin
            q_r <= d;
        end else begin
            q_r <= q_r;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/lambdar_barrier_serializer.sv
// lambdar_barrier_serializer: captures one NUM_LANES x DATAWIDTH parallel
// block and streams it out lane by lane over a valid/ready handshake.
// A new block may be loaded in the same cycle as the last-word transfer,
// giving gap-free back-to-back blocks; loads arriving mid-drain are ignored.
// Ports:
//   clock      : sole clock, rising edge
//   reset      : synchronous active-high reset (clears state and lane bank)
//   bus        : lambdar_barrier_serializer_if.slave (load/in_flat/out_ready in,
//                out_data/out_valid/out_index/out_last/busy out)
//   drop_count : 8-bit saturating count of ignored loads, present only when
//                LAMBDAR_SER_DROPCNT_EN is defined
module lambdar_barrier_serializer
    import lambdar_pkg::*;
#(
    parameter int DATAWIDTH = 8,
    parameter int NUM_LANES = LAMBDAR_NUM_LANES
) (
    input  logic                              clock,
    input  logic                              reset,
`ifdef LAMBDAR_SER_DROPCNT_EN
    output logic [7:0]                        drop_count,
`endif
    lambdar_barrier_serializer_if.slave       bus
);

    localparam logic [LAMBDAR_IDX_W-1:0] LAST_IDX = LAMBDAR_IDX_W'(NUM_LANES - 1);

    state_e                   state_r;
    state_e                   state_nxt_s;
    logic                     xfer_s;
    logic                     last_xfer_s;
    logic                     accept_s;
    logic [LAMBDAR_IDX_W-1:0] idx_nxt_s;
    logic [DATAWIDTH-1:0]     next_word_s;
    logic [DATAWIDTH-1:0]     lane_q_s [NUM_LANES];

    logic                     out_valid_r;
    logic [LAMBDAR_IDX_W-1:0] out_index_r;
    logic                     out_last_r;
    logic [DATAWIDTH-1:0]     out_data_r;

    // Capture bank: every lane loads together on an accepted load
    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        lambdar_barrier_serializer_reg #(.WIDTH(DATAWIDTH)) u_lane (
            .clock (clock),
            .reset (reset),
            .en    (accept_s),
            .d     (bus.in_flat[k*DATAWIDTH +: DATAWIDTH]),
            .q     (lane_q_s[k])
        );
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and handshake decode; out_valid comes only from a register
    always_comb begin
        state_nxt_s = state_r;
        xfer_s      = out_valid_r & bus.out_ready;
        last_xfer_s = out_valid_r & bus.out_ready & out_last_r;
        accept_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                accept_s = bus.load;
                if (bus.load) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                // Only the final transfer frees the bank for a new block
                accept_s = bus.load & last_xfer_s;
                if (last_xfer_s & ~bus.load) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Look up the lane word that follows the one currently presented
    always_comb begin
        idx_nxt_s   = out_index_r + LAMBDAR_IDX_W'(1);
        next_word_s = {DATAWIDTH{1'b0}};
        for (int k = 0; k < NUM_LANES; k++) begin
            if (idx_nxt_s == LAMBDAR_IDX_W'(k)) begin
                next_word_s = lane_q_s[k];
            end else begin
                next_word_s = next_word_s;
            end
        end
    end

    // Output word registers; lane 0 is taken straight from in_flat on capture
    // so it can be presented the cycle after the load
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid_r <= 1'b0;
            out_index_r <= {LAMBDAR_IDX_W{1'b0}};
            out_last_r  <= 1'b0;
            out_data_r  <= {DATAWIDTH{1'b0}};
        end else if (accept_s) begin
            out_valid_r <= 1'b1;
            out_index_r <= {LAMBDAR_IDX_W{1'b0}};
            out_last_r  <= 1'b0;
            out_data_r  <= bus.in_flat[DATAWIDTH-1:0];
        end else if (last_xfer_s) begin
            out_valid_r <= 1'b0;
            out_index_r <= {LAMBDAR_IDX_W{1'b0}};
            out_last_r  <= 1'b0;
            out_data_r  <= out_data_r;
        end else if (xfer_s) begin
            out_valid_r <= 1'b1;
            out_index_r <= idx_nxt_s;
            out_last_r  <= (idx_nxt_s == LAST_IDX);
            out_data_r  <= next_word_s;
        end else begin
            out_valid_r <= out_valid_r;
            out_index_r <= out_index_r;
            out_last_r  <= out_last_r;
            out_data_r  <= out_data_r;
        end
    end

    assign bus.out_valid = out_valid_r;
    assign bus.out_index = out_index_r;
    assign bus.out_last  = out_last_r;
    assign bus.out_data  = out_data_r;
    assign bus.busy      = (state_r == ST_DRAIN);

`ifdef LAMBDAR_SER_DROPCNT_EN
    logic       drop_s;
    logic [7:0] drop_count_r;

    assign drop_s = (state_r == ST_DRAIN) & bus.load & ~last_xfer_s;

    // Saturating count of loads refused while a block is draining
    always_ff @(posedge clock) begin
        if (reset) begin
            drop_count_r <= 8'd0;
        end else if (drop_s && (drop_count_r != 8'd255)) begin
            drop_count_r <= drop_count_r + 8'd1;
        end else begin
            drop_count_r <= drop_count_r;
        end
    end

    assign drop_count = drop_count_r;
`endif

endmodule

// File: tb/tb_lambdar_barrier_serializer.sv
// tb_lambdar_barrier_serializer: directed scenarios followed by randomized
// load/ready/reset traffic, every cycle compared against a block/position
// reference model of the serializer.
module tb_lambdar_barrier_serializer;
    import lambdar_pkg::*;

    localparam int DW = 8;
    localparam int NL = LAMBDAR_NUM_LANES;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    lambdar_barrier_serializer_if #(.DATAWIDTH(DW), .NUM_LANES(NL)) bus ();

`ifdef LAMBDAR_SER_DROPCNT_EN
    logic [7:0] drop_count;
`endif

    lambdar_barrier_serializer #(.DATAWIDTH(DW), .NUM_LANES(NL)) dut (
        .clock      (clock),
        .reset      (reset),
        .bus        (bus)
`ifdef LAMBDAR_SER_DROPCNT_EN
        , .drop_count (drop_count)
`endif
    );

    // Reference model: the held block, whether one is held, and the lane
    // position currently on offer.
    bit              m_held;
    int              m_pos;
    logic [DW-1:0]   m_blk [NL];
    int              m_drops;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NL*DW-1:0] make_flat(input int base);
        logic [NL*DW-1:0] f;
        f = '0;
        for (int k = 0; k < NL; k++) f[k*DW +: DW] = DW'(base + k);
        return f;
    endfunction

    function automatic logic [NL*DW-1:0] rand_flat();
        logic [NL*DW-1:0] f;
        f = '0;
        for (int k = 0; k < NL; k++) f[k*DW +: DW] = DW'($urandom);
        return f;
    endfunction

    // One clock: drive inputs, advance the model, then compare after the edge
    task automatic cycle(input logic ld, input logic [NL*DW-1:0] flat,
                         input logic rdy, input logic rst);
        bit xfer, lastx, acc;
        reset         = rst;
        bus.load      = ld;
        bus.in_flat   = flat;
        bus.out_ready = rdy;
        if (rst) begin
            m_held  = 1'b0;
            m_pos   = 0;
            m_drops = 0;
        end else begin
            xfer  = m_held && rdy;
            lastx = xfer && (m_pos == NL - 1);
            acc   = ld && (!m_held || lastx);
            if (ld && !acc && m_drops < 255) m_drops++;
            if (acc) begin
                for (int k = 0; k < NL; k++) m_blk[k] = flat[k*DW +: DW];
                m_held = 1'b1;
                m_pos  = 0;
            end else if (lastx) begin
                m_held = 1'b0;
                m_pos  = 0;
            end else if (xfer) begin
                m_pos++;
            end
        end
        @(posedge clock);
        #1;
        check("valid", 32'(bus.out_valid), 32'(m_held));
        check("busy",  32'(bus.busy),      32'(m_held));
        check("last",  32'(bus.out_last),  32'(m_held && (m_pos == NL - 1)));
        if (m_held) begin
            check("index", 32'(bus.out_index), 32'(m_pos));
            check("data",  32'(bus.out_data),  32'(m_blk[m_pos]));
        end else if (rst) begin
            check("rst_index", 32'(bus.out_index), 32'd0);
        end
`ifdef LAMBDAR_SER_DROPCNT_EN
        check("drop_count", 32'(drop_count), 32'(m_drops));
`endif
    endtask

    initial begin
        logic [NL*DW-1:0] blk_a, blk_b, blk_c, zero;
        blk_a = make_flat(16);   // 8'h10..8'h1B
        blk_b = make_flat(32);   // 8'h20..8'h2B
        blk_c = rand_flat();
        zero  = '0;
        m_held = 1'b0; m_pos = 0; m_drops = 0;

        // Reset state
        cycle(1'b0, zero, 1'b0, 1'b1);
        cycle(1'b1, blk_a, 1'b1, 1'b1);
        cycle(1'b0, zero, 1'b0, 1'b0);

        // Basic drain
        cycle(1'b1, blk_a, 1'b1, 1'b0);
        for (int i = 0; i < NL; i++) begin
            check("drain_data", 32'(bus.out_data), 32'(16 + i));
            check("drain_last", 32'(bus.out_last), 32'(i == NL - 1));
            cycle(1'b0, zero, 1'b1, 1'b0);
        end
        check("drain_end_valid", 32'(bus.out_valid), 32'd0);

        // Backpressure at index 5
        cycle(1'b1, blk_a, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, zero, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, zero, 1'b0, 1'b0);
            check("bp_data",  32'(bus.out_data),  32'h15);
            check("bp_index", 32'(bus.out_index), 32'd5);
        end
        for (int i = 0; i < 7; i++) cycle(1'b0, zero, 1'b1, 1'b0);

        // Back-to-back blocks, second load on the last transfer
        cycle(1'b1, blk_a, 1'b1, 1'b0);
        for (int i = 0; i < NL - 1; i++) cycle(1'b0, zero, 1'b1, 1'b0);
        cycle(1'b1, blk_b, 1'b1, 1'b0);
        check("b2b_valid", 32'(bus.out_valid), 32'd1);
        check("b2b_data",  32'(bus.out_data),  32'h20);
        for (int i = 0; i < NL; i++) cycle(1'b0, zero, 1'b1, 1'b0);

        // Ignored load at index 3
        cycle(1'b1, blk_a, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, zero, 1'b1, 1'b0);
        cycle(1'b1, blk_c, 1'b1, 1'b0);
        check("ign_data", 32'(bus.out_data), 32'h14);
`ifdef LAMBDAR_SER_DROPCNT_EN
        check("ign_drops", 32'(drop_count), 32'd1);
`endif
        for (int i = 0; i < NL - 4; i++) cycle(1'b0, zero, 1'b1, 1'b0);

        // Reset mid-operation at index 7, then restart with new data
        cycle(1'b1, blk_b, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) cycle(1'b0, zero, 1'b1, 1'b0);
        cycle(1'b0, zero, 1'b1, 1'b1);
        check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_busy",  32'(bus.busy),      32'd0);
        cycle(1'b1, blk_c, 1'b0, 1'b0);
        check("restart_index", 32'(bus.out_index), 32'd0);
        check("restart_data",  32'(bus.out_data),  32'(blk_c[DW-1:0]));
        for (int i = 0; i < NL; i++) cycle(1'b0, zero, 1'b1, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom % 4) == 0, rand_flat(), ($urandom % 3) != 0,
                  ($urandom % 64) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
